// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronizers, 11-bit deserializer, parity/stop/timeout checks.
// Optional make/break prefix decoding is enabled with `define PS2_RX_BREAK_DECODE_EN.
module ps2_rx_frame #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       err
`ifdef PS2_RX_BREAK_DECODE_EN
    ,
    output logic       brk,
    output logic       ext
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, data_s, fall;

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            good_frame, bad_frame, timeout;

`ifdef PS2_RX_BREAK_DECODE_EN
    logic pend_brk_q, pend_brk_d, pend_ext_q, pend_ext_d;
    logic brk_q, brk_d, ext_q, ext_d;
    logic is_prefix;
`endif

    // Idle bus is high, so synchronizers reset to 1 to avoid a false fall on release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tmo_d      = tmo_q;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        timeout    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fall && !data_s) begin
                    state_d   = StData;
                    bit_cnt_d = 3'd0;
                end
            end
            StData: begin
                if (fall) begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = StParity;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (data_s && (^{shift_q, parity_q})) good_frame = 1'b1;
                    else                                   bad_frame  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A fall in the terminal cycle takes priority over the timeout.
        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            timeout = 1'b1;
            state_d = StIdle;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_comb begin
        err_d   = bad_frame | timeout;
        valid_d = 1'b0;
        data_d  = data_q;
`ifdef PS2_RX_BREAK_DECODE_EN
        pend_brk_d = pend_brk_q;
        pend_ext_d = pend_ext_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        is_prefix  = (shift_q == 8'hF0) || (shift_q == 8'hE0);
        if (good_frame) begin
            if (shift_q == 8'hF0) begin
                pend_brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                pend_ext_d = 1'b1;
            end
            if (!is_prefix) begin
                valid_d    = 1'b1;
                data_d     = shift_q;
                brk_d      = pend_brk_q;
                ext_d      = pend_ext_q;
                pend_brk_d = 1'b0;
                pend_ext_d = 1'b0;
            end
        end
        if (err_d) begin
            pend_brk_d = 1'b0;
            pend_ext_d = 1'b0;
        end
`else
        if (good_frame) begin
            valid_d = 1'b1;
            data_d  = shift_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

`ifdef PS2_RX_BREAK_DECODE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_brk_q <= 1'b0;
            pend_ext_q <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            pend_brk_q <= pend_brk_d;
            pend_ext_q <= pend_ext_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
        end
    end

    assign brk = brk_q;
    assign ext = ext_q;
`endif

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: expected strobes are queued as frames are sent,
// observed strobes are collected by a monitor and compared inside each test task.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

    localparam int unsigned TIMEOUT = 5000;
    localparam time PS2_HALF = 40us;  // 12.5 kHz PS/2 clock

    typedef struct packed {
        logic       v;
        logic       e;
        logic [7:0] d;
        logic       b;
        logic       x;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       valid, err;
    logic       brk_w, ext_w;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   checks = 0;
    int   failures = 0;
    logic [7:0] model_data = 8'h00;
    logic       model_brk = 1'b0;
    logic       model_ext = 1'b0;

    ps2_rx_frame #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .data    (data),
        .valid   (valid),
        .err     (err)
`ifdef PS2_RX_BREAK_DECODE_EN
        ,
        .brk     (brk_w),
        .ext     (ext_w)
`endif
    );

`ifndef PS2_RX_BREAK_DECODE_EN
    assign brk_w = 1'b0;
    assign ext_w = 1'b0;
`endif

    always #500 clk = ~clk;  // 1 MHz system clock

    always @(negedge clk) begin
        if (reset_n && (valid || err)) obs_q.push_back({valid, err, data, brk_w, ext_w});
    end

    initial begin
        #60ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #(PS2_HALF);
        ps2_clk = 1'b0;
        #(PS2_HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~(^d) ^ par_flip);
        ps2_bit(stop);
        ps2_data = 1'b1;
        #(PS2_HALF);
    endtask

    task automatic expect_good(input logic [7:0] d, input logic b, input logic x);
        model_data = d;
        model_brk  = b;
        model_ext  = x;
        exp_q.push_back({1'b1, 1'b0, d, b, x});
    endtask

    task automatic expect_err();
        exp_q.push_back({1'b0, 1'b1, model_data, model_brk, model_ext});
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h expected 00", data);
        end
        checks++;
        if ({valid, err, brk_w, ext_w} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 0000", {valid, err, brk_w, ext_w});
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL reset_release: got %0d strobes expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_frames(input string name, input logic [7:0] d, input logic par_flip,
                               input logic stop);
        ev_t o, e;
        if (!par_flip && stop) expect_good(d, 1'b0, 1'b0);
        else                   expect_err();
        send_frame(d, par_flip, stop);
        repeat (20) @(posedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s count: got %0d strobes expected %0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s event: got v/e/d/b/x=%h expected %h", name, o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch();
        ps2_data = 1'b1;
        ps2_bit(1'b1);
        repeat (50) @(posedge clk);
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL idle_glitch: got %0d strobes expected 0", obs_q.size());
        end
        obs_q.delete();
        test_frames("after_glitch", 8'h3B, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        ev_t o, e;
        logic [7:0] d = 8'h6D;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(d[i]);
        ps2_data = 1'b1;
        expect_err();
        repeat (TIMEOUT + 10) @(posedge clk);
        checks++;
        if (obs_q.size() !== 1) begin
            failures++;
            $display("FAIL timeout_count: got %0d strobes expected 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL timeout_event: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
        test_frames("after_timeout", 8'h2A, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d = 8'hB7;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(d[i]);
        @(posedge clk);
        reset_n = 1'b0;
        model_data = 8'h00;
        model_brk  = 1'b0;
        model_ext  = 1'b0;
        repeat (5) @(posedge clk);
        reset_n = 1'b1;
        repeat (200) @(posedge clk);
        checks++;
        if (obs_q.size() !== 0 || data !== 8'h00) begin
            failures++;
            $display("FAIL reset_midframe: got %0d strobes data=%h expected 0 strobes data=00",
                     obs_q.size(), data);
        end
        obs_q.delete();
        test_frames("after_reset", 8'h45, 1'b0, 1'b1);
    endtask

    task automatic test_prefix_seq();
        ev_t o, e;
`ifdef PS2_RX_BREAK_DECODE_EN
        expect_good(8'h74, 1'b1, 1'b1);
`else
        expect_good(8'hE0, 1'b0, 1'b0);
        expect_good(8'hF0, 1'b0, 1'b0);
        expect_good(8'h74, 1'b0, 1'b0);
`endif
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL prefix_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL prefix_event: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
        test_frames("plain_after_prefix", 8'h1B, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        test_frames("b2b_a", 8'h5A, 1'b0, 1'b1);
        test_frames("b2b_b", 8'h00, 1'b0, 1'b1);
        test_frames("b2b_c", 8'hFF, 1'b0, 1'b1);
        checks++;
        if (data !== model_data) begin
            failures++;
            $display("FAIL b2b_hold: got data=%h expected %h", data, model_data);
        end
    endtask

    initial begin
        test_reset();
        test_frames("frame_1c", 8'h1C, 1'b0, 1'b1);
        test_frames("parity_err", 8'h1C, 1'b1, 1'b1);
        checks++;
        if (data !== 8'h1C) begin
            failures++;
            $display("FAIL parity_hold: got data=%h expected 1c", data);
        end
        test_frames("stop_err", 8'hF0, 1'b0, 1'b0);
        test_glitch();
        test_timeout();
        test_reset_midframe();
        test_prefix_seq();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
